// File: rtl/lsu_data_ram.sv
// lsu_data_ram
// Single-port data memory for the RV32I load/store unit. Executes
// LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane writes, sign/zero extension of
// loads, and fault reporting for misaligned accesses and illegal funct3.
// One request may be outstanding; the response is held until consumed.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset (the array is not reset)
//   req         request valid, accepted only while ready=1
//   we          1 = store, 0 = load (sampled with req)
//   funct3      RV32I funct3 of the access
//   addr        byte address
//   wdata       right-aligned store data
//   ready       block is idle and can accept a request
//   rvalid      response valid
//   rready      consumer accepts the response
//   rdata       extended load result; 0 for stores and faults
//   fault       qualifies rvalid: the request was rejected
//   fault_addr  address of the most recent faulting request
module lsu_data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t              state_reg;
  logic [31:0]         rdata_reg;
  logic                fault_reg;
  logic [ADDR_W-1:0]   fault_addr_reg;

  logic [ADDR_W-3:0]   word_idx;
  logic [1:0]          lane;
  logic                accept;
  logic                legal;
  logic                misaligned;
  logic                bad;
  logic                wr_en;
  logic [3:0]          be;
  logic [31:0]         wdata_lane;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_val;

  assign word_idx = addr[ADDR_W-1:2];
  assign lane     = addr[1:0];
  assign accept   = req && (state_reg == IDLE);

  // Access legality: unsigned loads have no store counterpart, and
  // alignment only matters for halfword and word sizes.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000: legal = 1'b1;
      3'b001: begin
        legal      = 1'b1;
        misaligned = addr[0];
      end
      3'b010: begin
        legal      = 1'b1;
        misaligned = |addr[1:0];
      end
      3'b100: legal = !we;
      3'b101: begin
        legal      = !we;
        misaligned = addr[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign bad   = !legal || misaligned;
  assign wr_en = accept && we && !bad;

  // Replicate the store data across lanes so each lane RAM sees its byte
  // on the same bit positions regardless of the address offset.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = wdata;
      end
    endcase
  end

  // One byte-wide array per lane: lane writes never collide and the
  // contents survive rst_n, but no write happens while reset is held.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (rst_n && wr_en && be[gi]) begin
        lane_mem[word_idx] <= wdata_lane[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
  end

  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  // Response is captured on the accept edge and held through RESP, so
  // rdata/fault stay stable however long the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rdata_reg      <= 32'h0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= RESP;
            if (bad) begin
              fault_reg      <= 1'b1;
              rdata_reg      <= 32'h0;
              fault_addr_reg <= addr;
            end else begin
              fault_reg <= 1'b0;
              rdata_reg <= we ? 32'h0 : load_val;
            end
          end
        end
        RESP: begin
          if (rready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready      = (state_reg == IDLE);
  assign rvalid     = (state_reg == RESP);
  assign rdata      = rdata_reg;
  assign fault      = fault_reg;
  assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_lsu_data_ram.sv
module tb_lsu_data_ram;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        fault;
  logic [7:0]  fault_addr;

  lsu_data_ram #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [7:0]  fa;
    string       nm;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_fa;
  int         compared;
  int         mismatched;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    compared++;
    if (act !== req_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req_v);
    end
  endtask

  // Monitor: a response completes on the edge after a negedge where
  // rvalid && rready, so each response is compared exactly once.
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_resp: rdata=0x%08h fault=%0b with no request pending", rdata, fault);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rdata !== e.rdata || fault !== e.fault || fault_addr !== e.fa) begin
          mismatched++;
          $display("FAIL %s: got rdata=0x%08h fault=%0b fault_addr=0x%02h expected rdata=0x%08h fault=%0b fault_addr=0x%02h",
                   e.nm, rdata, fault, fault_addr, e.rdata, e.fault, e.fa);
        end else begin
          $display("txn %-12s rdata=0x%08h fault=%0b fault_addr=0x%02h ok", e.nm, rdata, fault, fault_addr);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ef,
                       input string nm);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL %s_ready_timeout: ready=%0b required 1", nm, ready);
    end else begin
      req    = 1'b1;
      we     = w;
      funct3 = f3;
      addr   = a;
      wdata  = wd;
      if (ef) exp_fa = a;
      e.rdata = er;
      e.fault = ef;
      e.fa    = exp_fa;
      e.nm    = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req = 1'b0;
    end
  endtask

  initial begin
    int guard;
    compared   = 0;
    mismatched = 0;
    exp_fa     = 8'h00;
    rst_n  = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    funct3 = 3'b000;
    addr   = 8'h00;
    wdata  = 32'h0;
    rready = 1'b1;

    #1;
    check("reset_ready",  {31'h0, ready},  32'h1);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rdata",  rdata,           32'h0);
    check("reset_fault",  {31'h0, fault},  32'h0);
    check("reset_faddr",  {24'h0, fault_addr}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stores and sign/zero extended loads
    issue(1'b1, 3'b010, 8'h10, 32'h8000_00F1, 32'h0,          1'b0, "SW_10");
    issue(1'b0, 3'b010, 8'h10, 32'h0,         32'h8000_00F1, 1'b0, "LW_10");
    issue(1'b0, 3'b000, 8'h10, 32'h0,         32'hFFFF_FFF1, 1'b0, "LB_10");
    issue(1'b0, 3'b100, 8'h10, 32'h0,         32'h0000_00F1, 1'b0, "LBU_10");
    issue(1'b0, 3'b001, 8'h12, 32'h0,         32'hFFFF_8000, 1'b0, "LH_12");
    issue(1'b0, 3'b101, 8'h12, 32'h0,         32'h0000_8000, 1'b0, "LHU_12");

    // Byte and half lane writes into a zeroed word
    issue(1'b1, 3'b010, 8'h20, 32'h0000_0000, 32'h0,          1'b0, "SW_20");
    issue(1'b1, 3'b000, 8'h21, 32'h5555_55AB, 32'h0,          1'b0, "SB_21");
    issue(1'b1, 3'b001, 8'h22, 32'hCDEF_1234, 32'h0,          1'b0, "SH_22");
    issue(1'b0, 3'b010, 8'h20, 32'h0,         32'h1234_AB00, 1'b0, "LW_20");
    issue(1'b0, 3'b000, 8'h23, 32'h0,         32'h0000_0012, 1'b0, "LB_23");
    issue(1'b0, 3'b101, 8'h20, 32'h0,         32'h0000_AB00, 1'b0, "LHU_20");

    // Misalignment faults
    issue(1'b1, 3'b010, 8'h00, 32'h1122_3344, 32'h0,          1'b0, "SW_00");
    issue(1'b0, 3'b010, 8'h06, 32'h0,         32'h0,          1'b1, "LW_06_mis");
    issue(1'b1, 3'b001, 8'h03, 32'h0000_FFFF, 32'h0,          1'b1, "SH_03_mis");
    issue(1'b0, 3'b001, 8'h21, 32'h0,         32'h0,          1'b1, "LH_21_mis");
    issue(1'b0, 3'b010, 8'h00, 32'h0,         32'h1122_3344, 1'b0, "LW_00");

    // Illegal funct3
    issue(1'b1, 3'b010, 8'h04, 32'hA5A5_A5A5, 32'h0,          1'b0, "SW_04");
    issue(1'b0, 3'b011, 8'h04, 32'h0,         32'h0,          1'b1, "LD_ill_04");
    issue(1'b1, 3'b100, 8'h04, 32'hDEAD_BEEF, 32'h0,          1'b1, "ST100_ill");
    issue(1'b1, 3'b101, 8'h05, 32'hDEAD_BEEF, 32'h0,          1'b1, "ST101_ill");
    issue(1'b0, 3'b010, 8'h04, 32'h0,         32'hA5A5_A5A5, 1'b0, "LW_04");

    // Backpressure: response held for 5 cycles, stray request ignored
    @(posedge clk);
    #1;
    rready = 1'b0;
    issue(1'b0, 3'b010, 8'h20, 32'h0, 32'h1234_AB00, 1'b0, "LW_20_bp");
    req    = 1'b1;
    we     = 1'b1;
    funct3 = 3'b010;
    addr   = 8'h20;
    wdata  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", {31'h0, rvalid}, 32'h1);
      check("bp_ready",  {31'h0, ready},  32'h0);
      check("bp_rdata",  rdata,           32'h1234_AB00);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    rready = 1'b1;
    issue(1'b0, 3'b010, 8'h20, 32'h0, 32'h1234_AB00, 1'b0, "LW_20_after");

    // Reset while a response is pending
    @(posedge clk);
    #1;
    rready = 1'b0;
    issue(1'b0, 3'b010, 8'h10, 32'h0, 32'h8000_00F1, 1'b0, "LW_10_rst");
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata",  rdata,           32'h0);
    check("rst_fault",  {31'h0, fault},  32'h0);
    check("rst_ready",  {31'h0, ready},  32'h1);
    check("rst_faddr",  {24'h0, fault_addr}, 32'h0);
    sb_q.delete();
    exp_fa = 8'h00;
    @(negedge clk);
    rst_n  = 1'b1;
    rready = 1'b1;
    issue(1'b0, 3'b010, 8'h10, 32'h0, 32'h8000_00F1, 1'b0, "LW_10_post");
    issue(1'b0, 3'b010, 8'h04, 32'h0, 32'hA5A5_A5A5, 1'b0, "LW_04_post");

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
